wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised write-back stage for the pipelined MIPS core. It combines the MEM/WB pipeline register, load-data alignment and sign extension, write-back source selection and a halt state machine. It sits between the memory stage and the register file. It also exports the register-file write port and the halt flag used by the debug unit.

## Interface
- `DATA_W`, 32: datapath width. Must be a multiple of 8 and ≥ 32.
- `REG_ADDR_W`, 5: register-file address width.
- `CNT_W`, 32: retired-instruction counter width. Used only with `WB_RETIRE_CNT_EN`.
- `i_clk`  in  1  single clock. Everything is rising-edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  stage advance. Low means stall and hold all registers.
- `i_flush`  in  1  insert a bubble at the next edge.
- `i_valid_M`  in  1  incoming instruction is valid.
- `i_alu_result_M`  in  DATA_W  ALU result. Bits [1:0] give the load byte address.
- `i_read_data_M`  in  DATA_W  raw data-memory word.
- `i_branch_delay_slot_M`  in  DATA_W  return address (PC+8) for link instructions.
- `i_rd_M`  in  REG_ADDR_W  destination register.
- `i_reg_write_M`, `i_mem_to_reg_M`, `i_bds_sel_M`, `i_halt_M`  in  1 each  control lines.
- `i_load_size_M`  in  2  load size: 00 byte, 01 half, 10/11 word.
- `i_load_unsigned_M`  in  1  zero-extend instead of sign-extend.
- `o_write_data_W`  out  DATA_W  register-file write data.
- `o_rd_W`  out  REG_ADDR_W  register-file write address.
- `o_reg_write_W`  out  1  register-file write enable.
- `o_halt_W`  out  1  core halted (sticky).
- `o_retired_W`  out  CNT_W  retired-instruction count. Present only with the macro.

## Operation
- **Pipeline register.** Captures every `*_M` input on the rising edge while `i_enable`=1 and the state is RUN. Otherwise all fields hold.
- **Flush.** `i_flush`=1 clears the registered valid bit at the next edge, whatever the value of `i_enable`. Flush takes priority over capture. Other fields are don't-care.
- **Load alignment.** Operates on registered data, using `addr` = registered `alu_result[1:0]`, little-endian.
  - Byte: lane `addr`.
  - Half: lane `addr[1]`. `addr[0]` is ignored.
  - Word: passthrough.
  - Byte and half are extended to DATA_W with sign extension, or zero extension when the unsigned flag is set.
- **Source select**, combinational from registered fields, in priority order:
  - bds_sel=1 → branch delay slot value.
  - else mem_to_reg=1 → aligned load data.
  - else → ALU result.
- **Write enable.** `o_reg_write_W` = valid & reg_write & ~halt & (rd ≠ 0). Writes to `$0` are suppressed.
- `o_rd_W` is the registered rd.
- **State machine.** Two states: RUN and HALTED.
  - RUN→HALTED on the edge that captures a valid instruction with `i_halt_M`=1.
  - HALTED is left only by `i_reset`.
  - In HALTED: no captures, valid cleared at the first HALTED edge, `o_reg_write_W`=0, `i_enable` and `i_flush` ignored.
- **Outputs.** `o_halt_W`=1 exactly when the state is HALTED.

## Timing
- Latency: one cycle from M inputs to all W outputs. Write data settles combinationally after the register.
- Reset values: valid=0, all fields 0, state RUN. Therefore `o_write_data_W`=0, `o_rd_W`=0, `o_reg_write_W`=0, `o_halt_W`=0, `o_retired_W`=0.
- Reset asserted mid-stall or while HALTED: returns to RUN immediately (asynchronous).
- Stall (`i_enable`=0): outputs are held stable, so the register file may rewrite the same value.
- The halt instruction is visible in W for one cycle with `o_reg_write_W`=0. `o_halt_W` rises in that same cycle.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - Adds `o_retired_W`, a CNT_W counter.
  - Increments by 1 on each edge that captures a valid instruction in RUN, including the halt instruction.
  - Wraps modulo 2^CNT_W. Frozen while stalled or HALTED. Cleared by reset.
- Macro undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Reset.** Drive non-zero inputs, assert `i_reset` → all outputs 0. After release with valid ALU instruction (alu=0x0000_1234, rd=3, reg_write=1) → next cycle `o_write_data_W`=0x1234, `o_rd_W`=3, `o_reg_write_W`=1.
- **Loads.** read_data=0x80FF_7F01, mem_to_reg=1:
  - byte signed, addr=3 → 0xFFFF_FF80.
  - byte unsigned, addr=2 → 0x0000_00FF.
  - half signed, addr=0 → 0x0000_7F01.
  - half signed, addr=3 → 0xFFFF_80FF.
  - word → 0x80FF_7F01.
- **Link.** bds_sel=1, mem_to_reg=1, bds=0x0040_0010, rd=31 → write data 0x0040_0010 with write enabled. With rd=0 → `o_reg_write_W`=0.
- **Stall/flush.**
  - `i_enable`=0 for 3 cycles with changing inputs → outputs frozen.
  - `i_flush`=1 together with `i_enable`=0 → next cycle `o_reg_write_W`=0.
- **Halt.** Valid halt instruction followed by 2 valid writes → `o_halt_W`=1 from the halt cycle, `o_reg_write_W` stays 0 thereafter. Reset → RUN.
- **Counter (macro on, CNT_W=4).** 17 valid captures with one flush and two stalls interleaved → `o_retired_W`=1 (wrapped). Halt → count frozen.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load alignment/extension, WB source mux, halt FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid_M,
  input  logic [DATA_W-1:0]     i_alu_result_M,
  input  logic [DATA_W-1:0]     i_read_data_M,
  input  logic [DATA_W-1:0]     i_branch_delay_slot_M,
  input  logic [REG_ADDR_W-1:0] i_rd_M,
  input  logic                  i_reg_write_M,
  input  logic                  i_mem_to_reg_M,
  input  logic                  i_bds_sel_M,
  input  logic                  i_halt_M,
  input  logic [1:0]            i_load_size_M,
  input  logic                  i_load_unsigned_M,
  output logic [DATA_W-1:0]     o_write_data_W,
  output logic [REG_ADDR_W-1:0] o_rd_W,
  output logic                  o_reg_write_W,
  output logic                  o_halt_W
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      o_retired_W
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    valid_q;
  logic [DATA_W-1:0]       alu_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [DATA_W-1:0]       bds_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic                    reg_write_q;
  logic                    mem_to_reg_q;
  logic                    bds_sel_q;
  logic                    halt_q;
  logic [1:0]              load_size_q;
  logic                    load_unsigned_q;

  logic                    capture;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [DATA_W-1:0]       load_data;

  assign capture = (state_q == RUN) && i_enable && !i_flush;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= RUN;
      valid_q         <= 1'b0;
      alu_q           <= '0;
      rdata_q         <= '0;
      bds_q           <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      bds_sel_q       <= 1'b0;
      halt_q          <= 1'b0;
      load_size_q     <= '0;
      load_unsigned_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (i_flush) begin
            valid_q <= 1'b0;
          end else if (i_enable) begin
            valid_q         <= i_valid_M;
            alu_q           <= i_alu_result_M;
            rdata_q         <= i_read_data_M;
            bds_q           <= i_branch_delay_slot_M;
            rd_q            <= i_rd_M;
            reg_write_q     <= i_reg_write_M;
            mem_to_reg_q    <= i_mem_to_reg_M;
            bds_sel_q       <= i_bds_sel_M;
            halt_q          <= i_halt_M;
            load_size_q     <= i_load_size_M;
            load_unsigned_q <= i_load_unsigned_M;
            if (i_valid_M && i_halt_M) begin
              state_q <= HALTED;
            end
          end
        end
        HALTED: begin
          // Only reset leaves HALTED; the halt instruction drains after one cycle.
          valid_q <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_retired_W <= '0;
    end else if (capture && i_valid_M) begin
      o_retired_W <= o_retired_W + 1'b1;
    end
  end
`endif

  always_comb begin
    byte_lane = '0;
    half_lane = '0;
    load_data = '0;
    case (alu_q[1:0])
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    half_lane = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (load_size_q)
      2'b00:   load_data = {{(DATA_W-8){byte_lane[7] & ~load_unsigned_q}}, byte_lane};
      2'b01:   load_data = {{(DATA_W-16){half_lane[15] & ~load_unsigned_q}}, half_lane};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    o_write_data_W = alu_q;
    if (bds_sel_q) begin
      o_write_data_W = bds_q;
    end else if (mem_to_reg_q) begin
      o_write_data_W = load_data;
    end
  end

  assign o_rd_W        = rd_q;
  assign o_reg_write_W = valid_q && reg_write_q && !halt_q && (rd_q != '0);
  assign o_halt_W      = (state_q == HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage; counter checks run when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_flush;
  logic        i_valid_M;
  logic [31:0] i_alu_result_M;
  logic [31:0] i_read_data_M;
  logic [31:0] i_branch_delay_slot_M;
  logic [4:0]  i_rd_M;
  logic        i_reg_write_M;
  logic        i_mem_to_reg_M;
  logic        i_bds_sel_M;
  logic        i_halt_M;
  logic [1:0]  i_load_size_M;
  logic        i_load_unsigned_M;
  logic [31:0] o_write_data_W;
  logic [4:0]  o_rd_W;
  logic        o_reg_write_W;
  logic        o_halt_W;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0]  o_retired_W;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 i_clk = ~i_clk;

`ifdef WB_RETIRE_CNT_EN
  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
`else
  wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
`endif
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_flush(i_flush),
    .i_valid_M(i_valid_M),
    .i_alu_result_M(i_alu_result_M),
    .i_read_data_M(i_read_data_M),
    .i_branch_delay_slot_M(i_branch_delay_slot_M),
    .i_rd_M(i_rd_M),
    .i_reg_write_M(i_reg_write_M),
    .i_mem_to_reg_M(i_mem_to_reg_M),
    .i_bds_sel_M(i_bds_sel_M),
    .i_halt_M(i_halt_M),
    .i_load_size_M(i_load_size_M),
    .i_load_unsigned_M(i_load_unsigned_M),
    .o_write_data_W(o_write_data_W),
    .o_rd_W(o_rd_W),
    .o_reg_write_W(o_reg_write_W),
    .o_halt_W(o_halt_W)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retired_W(o_retired_W)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_enable              = 1'b1;
    i_flush               = 1'b0;
    i_valid_M             = 1'b0;
    i_alu_result_M        = '0;
    i_read_data_M         = '0;
    i_branch_delay_slot_M = '0;
    i_rd_M                = '0;
    i_reg_write_M         = 1'b0;
    i_mem_to_reg_M        = 1'b0;
    i_bds_sel_M           = 1'b0;
    i_halt_M              = 1'b0;
    i_load_size_M         = 2'b10;
    i_load_unsigned_M     = 1'b0;
  endtask

  task automatic alu_instr(input logic [31:0] alu, input logic [4:0] rd);
    idle_inputs();
    i_valid_M      = 1'b1;
    i_reg_write_M  = 1'b1;
    i_alu_result_M = alu;
    i_rd_M         = rd;
  endtask

  task automatic load_instr(input logic [1:0] addr, input logic [1:0] size, input logic uns);
    idle_inputs();
    i_valid_M         = 1'b1;
    i_reg_write_M     = 1'b1;
    i_mem_to_reg_M    = 1'b1;
    i_rd_M            = 5'd5;
    i_read_data_M     = 32'h80FF_7F01;
    i_alu_result_M    = {30'h0000_1000, addr};
    i_load_size_M     = size;
    i_load_unsigned_M = uns;
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    alu_instr(32'hDEAD_BEEF, 5'd17);
    i_bds_sel_M = 1'b1;
    i_branch_delay_slot_M = 32'h1111_2222;
    step();
    step();
    check("rst_data", o_write_data_W, 32'h0);
    check("rst_rd", {27'h0, o_rd_W}, 32'h0);
    check("rst_we", {31'h0, o_reg_write_W}, 32'h0);
    check("rst_halt", {31'h0, o_halt_W}, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_cnt", {28'h0, o_retired_W}, 32'h0);
`endif

    i_reset = 1'b0;
    alu_instr(32'h0000_1234, 5'd3);
    step();
    check("alu_data", o_write_data_W, 32'h0000_1234);
    check("alu_rd", {27'h0, o_rd_W}, 32'd3);
    check("alu_we", {31'h0, o_reg_write_W}, 32'd1);

    load_instr(2'd3, 2'b00, 1'b0); step(); check("lb_a3", o_write_data_W, 32'hFFFF_FF80);
    check("ld_we", {31'h0, o_reg_write_W}, 32'd1);
    load_instr(2'd2, 2'b00, 1'b1); step(); check("lbu_a2", o_write_data_W, 32'h0000_00FF);
    load_instr(2'd0, 2'b01, 1'b0); step(); check("lh_a0", o_write_data_W, 32'h0000_7F01);
    load_instr(2'd3, 2'b01, 1'b0); step(); check("lh_a3", o_write_data_W, 32'hFFFF_80FF);
    load_instr(2'd1, 2'b01, 1'b1); step(); check("lhu_a1", o_write_data_W, 32'h0000_7F01);
    load_instr(2'd1, 2'b00, 1'b0); step(); check("lb_a1", o_write_data_W, 32'h0000_007F);
    load_instr(2'd2, 2'b10, 1'b0); step(); check("lw", o_write_data_W, 32'h80FF_7F01);
    load_instr(2'd1, 2'b11, 1'b1); step(); check("lw11", o_write_data_W, 32'h80FF_7F01);

    alu_instr(32'h0000_0999, 5'd31);
    i_bds_sel_M = 1'b1;
    i_mem_to_reg_M = 1'b1;
    i_branch_delay_slot_M = 32'h0040_0010;
    i_read_data_M = 32'h1234_5678;
    step();
    check("link_data", o_write_data_W, 32'h0040_0010);
    check("link_we", {31'h0, o_reg_write_W}, 32'd1);
    i_rd_M = 5'd0;
    step();
    check("r0_we", {31'h0, o_reg_write_W}, 32'd0);
    check("r0_data", o_write_data_W, 32'h0040_0010);

    alu_instr(32'h0000_AAAA, 5'd7);
    step();
    for (int i = 0; i < 3; i++) begin
      alu_instr(32'h0000_0100 + i, 5'd12 + 5'(i));
      i_enable = 1'b0;
      step();
      check("stall_data", o_write_data_W, 32'h0000_AAAA);
      check("stall_rd", {27'h0, o_rd_W}, 32'd7);
      check("stall_we", {31'h0, o_reg_write_W}, 32'd1);
    end
    i_flush = 1'b1;
    step();
    check("flush_we", {31'h0, o_reg_write_W}, 32'd0);
    alu_instr(32'h0000_0042, 5'd8);
    step();
    check("post_flush_data", o_write_data_W, 32'h0000_0042);
    check("post_flush_we", {31'h0, o_reg_write_W}, 32'd1);

    alu_instr(32'h0000_0055, 5'd9);
    i_halt_M = 1'b1;
    step();
    check("halt_flag", {31'h0, o_halt_W}, 32'd1);
    check("halt_we", {31'h0, o_reg_write_W}, 32'd0);
    check("halt_rd", {27'h0, o_rd_W}, 32'd9);
    for (int i = 0; i < 2; i++) begin
      alu_instr(32'h0000_0300 + i, 5'd20);
      i_flush = 1'(i);
      step();
      check("halted_flag", {31'h0, o_halt_W}, 32'd1);
      check("halted_we", {31'h0, o_reg_write_W}, 32'd0);
      check("halted_rd", {27'h0, o_rd_W}, 32'd9);
    end
    i_reset = 1'b1;
    #1;
    check("async_rst_halt", {31'h0, o_halt_W}, 32'd0);
    check("async_rst_rd", {27'h0, o_rd_W}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    alu_instr(32'h0000_0077, 5'd4);
    step();
    check("rerun_data", o_write_data_W, 32'h0000_0077);
    check("rerun_we", {31'h0, o_reg_write_W}, 32'd1);

`ifdef WB_RETIRE_CNT_EN
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alu_instr(32'h0000_0010 + i, 5'd2);
      if (i == 5) i_flush = 1'b1;
      if (i == 9 || i == 14) i_enable = 1'b0;
      step();
    end
    check("cnt_wrap", {28'h0, o_retired_W}, 32'd1);
    alu_instr(32'h0000_0001, 5'd2);
    i_halt_M = 1'b1;
    step();
    check("cnt_halt", {28'h0, o_retired_W}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      alu_instr(32'h0000_0002, 5'd2);
      step();
    end
    check("cnt_frozen", {28'h0, o_retired_W}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
